// File: rtl/jtag_work_link_pkg.sv
// Shared definitions for the JTAG work link: host command codes,
// work-unit geometry and the parser/transmitter state encodings.
package jtag_link_pkg;

    localparam logic [7:0] CMD_LOAD   = 8'h01;
    localparam logic [7:0] CMD_PING   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    localparam int WORK_BYTES = 44;
    localparam int WORK_BITS  = WORK_BYTES * 8;
    localparam logic [5:0] LAST_IDX = 6'(WORK_BYTES - 1);

    typedef enum logic {
        P_IDLE,
        P_LOAD
    } pstate_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_NONCE,
        T_PING,
        T_STAT
    } tstate_t;

    // Payload byte k (1..4) of a nonce frame, least significant first.
    function automatic logic [7:0] nonce_byte(
        input logic [31:0] n,
        input logic [2:0]  k
    );
        logic [7:0] b;
        case (k)
            3'd1:    b = n[7:0];
            3'd2:    b = n[15:8];
            3'd3:    b = n[23:16];
            3'd4:    b = n[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtag_work_link_if.sv
// Byte-FIFO pair seen from the rx_clk side: a 9-bit host-to-FPGA
// read port and an 8-bit FPGA-to-host write port.
interface jtag_work_link_if;

    logic [8:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_wr_data;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport master (
        input  fifo_rd_data,
        input  fifo_empty,
        input  fifo_full,
        output fifo_rd_en,
        output fifo_wr_data,
        output fifo_wr_en
    );

    modport slave (
        output fifo_rd_data,
        output fifo_empty,
        output fifo_full,
        input  fifo_rd_en,
        input  fifo_wr_data,
        input  fifo_wr_en
    );

endinterface

// File: rtl/jtag_work_link_nonce_queue.sv
// Circular nonce FIFO. A push into a full queue is dropped unless a
// pop frees the slot in the same cycle, in which case both succeed.
module nonce_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [31:0] pop_data_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign pop_data_o = mem_q[rptr_q];

    // Occupancy next state from the accepted push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jtag_work_link.sv
// JTAG work link: parses host commands into 44-byte work units and
// serialises nonce frames plus ping/status replies back to the host.
module jtag_work_link
    import jtag_link_pkg::*;
#(
    parameter int         NONCE_DEPTH   = 4,
    parameter logic [7:0] PING_RESPONSE = 8'hA5,
    parameter logic [7:0] NONCE_HEADER  = 8'h4E
) (
    input  logic             rx_clk,
    input  logic             reset,
    jtag_work_link_if.master fifo,
    output logic [255:0]     midstate,
    output logic [95:0]      data,
    output logic             work_valid,
    input  logic [31:0]      golden_nonce,
    input  logic             golden_nonce_valid,
    output logic             nonce_overflow
);

    pstate_t              pstate_q;
    logic [5:0]           cnt_q;
    logic [WORK_BITS-1:0] stage_q;
    logic [WORK_BITS-1:0] stage_d;
    logic                 rd_inflight_q;

    tstate_t    tstate_q;
    logic [2:0] k_q;
    logic [7:0] wr_data_q;
    logic       ping_pend_q;
    logic       stat_pend_q;
    logic       ovf_q;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       ping_set;
    logic       stat_set;
    logic       tx_write;
    logic       q_pop;
    logic       q_empty;
    logic       q_full;
    logic [31:0] q_data;
    logic       drop;
    logic       ovf_clr;
    logic [7:0] status_byte;

    // Single outstanding read; pending replies throttle the host.
    assign fifo.fifo_rd_en = ~reset & ~fifo.fifo_empty & ~rd_inflight_q
                           & ~ping_pend_q & ~stat_pend_q;

    assign rx_valid = rd_inflight_q & fifo.fifo_rd_data[8];
    assign rx_byte  = fifo.fifo_rd_data[7:0];
    assign stage_d  = {rx_byte, stage_q[WORK_BITS-1:8]};

    assign ping_set = rx_valid && pstate_q == P_IDLE && rx_byte == CMD_PING;
    assign stat_set = rx_valid && pstate_q == P_IDLE && rx_byte == CMD_STATUS;

    assign tx_write = (tstate_q != T_IDLE) && !fifo.fifo_full;
    assign q_pop    = tx_write && tstate_q == T_NONCE && k_q == 3'd4;
    assign ovf_clr  = tx_write && tstate_q == T_STAT;
    assign drop     = golden_nonce_valid & q_full & ~q_pop;

    // Status reflects live flags so a drop during a stall is reported.
    assign status_byte = {6'b0, ~q_empty, ovf_q};

    assign fifo.fifo_wr_en   = tx_write;
    assign fifo.fifo_wr_data = (tstate_q == T_STAT) ? status_byte : wr_data_q;
    assign nonce_overflow    = ovf_q;

    nonce_queue #(
        .DEPTH(NONCE_DEPTH)
    ) u_queue (
        .clk_i      (rx_clk),
        .rst_i      (reset),
        .push_i     (golden_nonce_valid),
        .push_data_i(golden_nonce),
        .pop_i      (q_pop),
        .pop_data_o (q_data),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    // Command parser and work-unit assembly.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            pstate_q      <= P_IDLE;
            cnt_q         <= '0;
            stage_q       <= '0;
            midstate      <= '0;
            data          <= '0;
            work_valid    <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            rd_inflight_q <= fifo.fifo_rd_en;
            work_valid    <= 1'b0;
            if (rx_valid) begin
                unique case (pstate_q)
                    P_IDLE: begin
                        if (rx_byte == CMD_LOAD) begin
                            pstate_q <= P_LOAD;
                            cnt_q    <= '0;
                        end
                    end
                    P_LOAD: begin
                        stage_q <= stage_d;
                        cnt_q   <= cnt_q + 6'd1;
                        if (cnt_q == LAST_IDX) begin
                            midstate   <= stage_d[255:0];
                            data       <= stage_d[WORK_BITS-1:256];
                            work_valid <= 1'b1;
                            pstate_q   <= P_IDLE;
                        end
                    end
                    default: pstate_q <= P_IDLE;
                endcase
            end
        end
    end

    // Sticky drop flag, cleared by a status write unless a new drop lands.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= drop | (ovf_q & ~ovf_clr);
        end
    end

    // Transmitter: status, then ping, then whole nonce frames.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            tstate_q    <= T_IDLE;
            k_q         <= '0;
            wr_data_q   <= '0;
            ping_pend_q <= 1'b0;
            stat_pend_q <= 1'b0;
        end else begin
            if (ping_set) begin
                ping_pend_q <= 1'b1;
            end
            if (stat_set) begin
                stat_pend_q <= 1'b1;
            end
            unique case (tstate_q)
                T_IDLE: begin
                    if (stat_pend_q) begin
                        tstate_q <= T_STAT;
                    end else if (ping_pend_q) begin
                        tstate_q  <= T_PING;
                        wr_data_q <= PING_RESPONSE;
                    end else if (!q_empty) begin
                        tstate_q  <= T_NONCE;
                        k_q       <= '0;
                        wr_data_q <= NONCE_HEADER;
                    end
                end
                T_NONCE: begin
                    if (tx_write) begin
                        if (k_q == 3'd4) begin
                            tstate_q  <= T_IDLE;
                            wr_data_q <= '0;
                        end else begin
                            k_q       <= k_q + 3'd1;
                            wr_data_q <= nonce_byte(q_data, k_q + 3'd1);
                        end
                    end
                end
                T_PING: begin
                    if (tx_write) begin
                        ping_pend_q <= 1'b0;
                        tstate_q    <= T_IDLE;
                        wr_data_q   <= '0;
                    end
                end
                T_STAT: begin
                    if (tx_write) begin
                        stat_pend_q <= 1'b0;
                        tstate_q    <= T_IDLE;
                    end
                end
                default: tstate_q <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_work_link.sv
// Scoreboard bench for jtag_work_link: host FIFO model, work-unit and
// frame-level reply checking against a queue-based reference model.
module tb_jtag_work_link;
    import jtag_link_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         work_valid;
    logic [31:0]  gn = '0;
    logic         gnv = 1'b0;
    logic         novf;

    always #5 clk = ~clk;

    jtag_work_link_if ifc();

    jtag_work_link #(
        .NONCE_DEPTH  (DEPTH),
        .PING_RESPONSE(8'hA5),
        .NONCE_HEADER (8'h4E)
    ) dut (
        .rx_clk            (clk),
        .reset             (reset),
        .fifo              (ifc),
        .midstate          (midstate),
        .data              (data),
        .work_valid        (work_valid),
        .golden_nonce      (gn),
        .golden_nonce_valid(gnv),
        .nonce_overflow    (novf)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0]   host_q[$];
    logic [351:0] work_q[$];
    logic [31:0]  mq[$];
    logic [351:0] cur = '0;
    logic [7:0]   last_stat = '0;
    bit rd_pend = 0;
    bit tb_inflight = 0;
    bit gap_en = 0;
    bit model_ovf = 0;
    int ping_exp = 0;
    int stat_exp = 0;
    int fpos = 0;

    task automatic chk(input string nm, input logic [351:0] act,
                       input logic [351:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Host-to-FPGA FIFO: data appears the cycle after a pop request.
    always @(posedge clk) begin
        #1;
        if (rd_pend) begin
            rd_pend = 0;
            if (host_q.size() != 0) ifc.fifo_rd_data = host_q.pop_front();
        end
        ifc.fifo_empty = (host_q.size() == 0) ||
                         (gap_en && $urandom_range(0, 3) == 0);
    end

    // Monitor: reference model of work, nonce queue and reply frames.
    always @(negedge clk) begin
        bit pop;
        bit stw;
        bit drop;
        logic [7:0] b;
        if (reset) begin
            mq.delete();
            model_ovf = 0;
            fpos = 0;
            cur = '0;
            tb_inflight = 0;
        end else begin
            if (ifc.fifo_rd_en) begin
                chk("rd_en_legal", 352'({ifc.fifo_empty, tb_inflight}), 352'(0));
                rd_pend = 1;
            end
            tb_inflight = ifc.fifo_rd_en;

            if (work_valid) begin
                chk("work_expected", 352'(work_q.size() != 0), 352'(1));
                if (work_q.size() != 0) begin
                    cur = work_q.pop_front();
                    chk("work_unit", {data, midstate}, cur);
                end
            end else begin
                chk("work_hold", {data, midstate}, cur);
            end

            chk("overflow_flag", 352'(novf), 352'(model_ovf));

            pop = 0;
            stw = 0;
            if (ifc.fifo_wr_en) begin
                b = ifc.fifo_wr_data;
                chk("wr_not_full", 352'(ifc.fifo_full), 352'(0));
                if (fpos != 0) begin
                    chk("nonce_byte", 352'(b), 352'(mq[0][8*(fpos-1) +: 8]));
                    fpos++;
                    if (fpos == 5) begin
                        fpos = 0;
                        pop = 1;
                    end
                end else if (b == 8'h4E) begin
                    chk("nonce_frame_expected", 352'(mq.size() != 0), 352'(1));
                    if (mq.size() != 0) fpos = 1;
                end else if (b == 8'hA5) begin
                    chk("ping_expected", 352'(ping_exp > 0), 352'(1));
                    ping_exp--;
                end else begin
                    chk("status_expected", 352'(stat_exp > 0), 352'(1));
                    chk("status_byte_value", 352'(b),
                        352'({6'b0, mq.size() != 0, model_ovf}));
                    stat_exp--;
                    last_stat = b;
                    stw = 1;
                end
            end

            drop = gnv && mq.size() == DEPTH && !pop;
            if (pop) void'(mq.pop_front());
            if (gnv && !drop) mq.push_back(gn);
            model_ovf = drop ? 1'b1 : (stw ? 1'b0 : model_ovf);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input bit v, input logic [7:0] b);
        host_q.push_back({v, b});
    endtask

    task automatic send_cmd(input logic [7:0] b);
        put(1'b1, b);
        if (b == CMD_PING) ping_exp++;
        if (b == CMD_STATUS) stat_exp++;
    endtask

    task automatic send_load(input logic [7:0] p[44], input int n,
                             input bit noise);
        logic [351:0] e;
        e = '0;
        put(1'b1, CMD_LOAD);
        for (int i = 0; i < n; i++) begin
            if (noise && (i == 20 || $urandom_range(0, 5) == 0))
                put(1'b0, 8'($urandom));
            put(1'b1, p[i]);
            e[8*i +: 8] = p[i];
        end
        if (n == 44) work_q.push_back(e);
    endtask

    task automatic strobe_burst(input int n);
        for (int i = 0; i < n; i++) begin
            gn = $urandom;
            gnv = 1'b1;
            step(1);
        end
        gnv = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(host_q.size() == 0 && !rd_pend && mq.size() == 0 &&
                 ping_exp == 0 && stat_exp == 0 && work_q.size() == 0 &&
                 fpos == 0) && t < 5000) begin
            step(1);
            t++;
        end
        step(3);
        chk("drain_in_time", 352'(t < 5000), 352'(1));
    endtask

    task automatic wait_fpos(input int target);
        int t;
        t = 0;
        while (fpos != target && t < 300) begin
            step(1);
            t++;
        end
        chk("reach_frame_pos", 352'(fpos), 352'(target));
    endtask

    task automatic check_reset_outputs();
        chk("rst_midstate", 352'(midstate), 352'(0));
        chk("rst_data", 352'(data), 352'(0));
        chk("rst_work_valid", 352'(work_valid), 352'(0));
        chk("rst_overflow", 352'(novf), 352'(0));
        chk("rst_wr_en", 352'(ifc.fifo_wr_en), 352'(0));
        chk("rst_wr_data", 352'(ifc.fifo_wr_data), 352'(0));
        chk("rst_rd_en", 352'(ifc.fifo_rd_en), 352'(0));
    endtask

    initial begin
        logic [7:0] p[44];
        int t;
        ifc.fifo_rd_data = '0;
        ifc.fifo_empty = 1'b1;
        ifc.fifo_full = 1'b0;
        step(3);
        check_reset_outputs();
        reset = 1'b0;
        step(2);

        for (int i = 0; i < 44; i++) p[i] = 8'(i);
        send_load(p, 44, 1'b0);
        wait_idle();
        chk("ms_first_byte", 352'(midstate[7:0]), 352'(8'h00));
        chk("ms_last_byte", 352'(midstate[255:248]), 352'(8'h1F));
        chk("data_last_byte", 352'(data[95:88]), 352'(8'h2B));

        for (int i = 0; i < 44; i++) p[i] = 8'(8'hFF - i);
        send_load(p, 44, 1'b0);
        wait_idle();
        for (int i = 0; i < 44; i++) p[i] = 8'(i);
        gap_en = 1;
        send_load(p, 44, 1'b1);
        wait_idle();
        gap_en = 0;

        gn = 32'hDEADBEEF;
        gnv = 1'b1;
        step(1);
        gnv = 1'b0;
        wait_fpos(2);
        ifc.fifo_full = 1'b1;
        step(10);
        ifc.fifo_full = 1'b0;
        wait_idle();

        ifc.fifo_full = 1'b1;
        step(1);
        strobe_burst(5);
        step(3);
        chk("overflow_after_burst", 352'(novf), 352'(1));
        send_cmd(CMD_STATUS);
        step(8);
        ifc.fifo_full = 1'b0;
        wait_idle();
        chk("status_after_burst", 352'(last_stat), 352'(8'h03));
        chk("overflow_cleared", 352'(novf), 352'(0));

        ifc.fifo_full = 1'b1;
        strobe_burst(1);
        step(2);
        send_cmd(CMD_PING);
        step(8);
        ifc.fifo_full = 1'b0;
        wait_idle();

        for (int i = 0; i < 44; i++) p[i] = 8'($urandom);
        send_load(p, 20, 1'b0);
        t = 0;
        while (host_q.size() != 0 && t < 200) begin
            step(1);
            t++;
        end
        step(4);
        reset = 1'b1;
        step(1);
        check_reset_outputs();
        step(2);
        reset = 1'b0;
        step(2);
        for (int i = 0; i < 44; i++) p[i] = 8'($urandom);
        send_load(p, 44, 1'b0);
        wait_idle();

        for (int it = 0; it < 80; it++) begin
            gap_en = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    for (int i = 0; i < 44; i++) p[i] = 8'($urandom);
                    send_load(p, 44, gap_en);
                end
                3: send_cmd(CMD_PING);
                4: send_cmd(CMD_STATUS);
                5, 6, 7: strobe_burst($urandom_range(1, 3));
                8: ifc.fifo_full = ($urandom_range(0, 1) == 1);
                default: put(1'b0, 8'($urandom));
            endcase
            step($urandom_range(0, 6));
        end
        ifc.fifo_full = 1'b0;
        gap_en = 0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
